// File: rtl/nios_system_pio_pkg.sv
// Package shared by the parametrised Nios PIO slave.
// Holds the register word addresses seen on the Avalon-MM slave port and
// the encodings of the EDGE_TYPE and IRQ_TYPE parameters.
package nios_system_pio_pkg;

  // Register word addresses
  localparam logic [2:0] PIO_DATA = 3'd0;  // data out / pin read-back
  localparam logic [2:0] PIO_DIR  = 3'd1;  // direction, 1 = bit driven
  localparam logic [2:0] PIO_MASK = 3'd2;  // interrupt mask
  localparam logic [2:0] PIO_EDGE = 3'd3;  // edge capture, write-1-to-clear
  localparam logic [2:0] PIO_SET  = 3'd4;  // write-only bit set of data out
  localparam logic [2:0] PIO_CLR  = 3'd5;  // write-only bit clear of data out

  // EDGE_TYPE encodings
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // IRQ_TYPE encodings
  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/nios_system_pio_sync.sv
// Input synchroniser and edge detector for the PIO slave.
// Each of the WIDTH asynchronous inputs passes through SYNC_STAGES flops to
// give sync_in; one further flop holds the previous synchronised value so
// that the selected edge can be detected combinationally.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset, clears every flop
//   in_port  in   WIDTH asynchronous external inputs
//   sync_in  out  WIDTH synchronised inputs
//   edge_det out  WIDTH one-cycle edge flags (type chosen by EDGE_TYPE)
module nios_system_pio_sync
  import nios_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_det
);

  // Element 0 is the first (metastability-exposed) stage.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], in_port};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = chain_q[SYNC_STAGES-1];

  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = ~sync_in & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = (sync_in & ~prev_q) | (~sync_in & prev_q);
    end else begin
      edge_det = sync_in & ~prev_q;
    end
  end

endmodule

// File: rtl/nios_system_pio_gen.sv
// Parametrised Avalon-MM PIO slave for the Nios data master.
// Per-bit direction, data/set/clear output registers, synchronised inputs,
// edge-capture register and a masked, registered interrupt.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   address    in   3-bit register word address
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   32-bit write data, bits above WIDTH ignored
//   readdata   out  32-bit combinational read data, zero wait states
//   in_port    in   WIDTH asynchronous external inputs
//   out_port   out  WIDTH output data register
//   out_en     out  WIDTH direction register, 1 = bit driven
//   irq        out  registered interrupt request
module nios_system_pio_gen
  import nios_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned      IRQ_TYPE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("nios_system_pio_gen: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("nios_system_pio_gen: SYNC_STAGES must be 2..4");
  end
  if (EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
    $error("nios_system_pio_gen: EDGE_TYPE must be 0..2");
  end
  if (IRQ_TYPE > IRQ_EDGE) begin : g_bad_irq
    $error("nios_system_pio_gen: IRQ_TYPE must be 0..1");
  end

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q,  cap_d;
  logic             irq_q,  irq_d;

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] rd_val;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  // Upper write-data bits are architecturally ignored.
  assign unused_wd = ^writedata;

  nios_system_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync_in (sync_in),
    .edge_det(edge_det)
  );

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    cap_d  = cap_q;
    irq_d  = 1'b0;

    if (wr_en) begin
      unique case (address)
        PIO_DATA: data_d = wd;
        PIO_DIR:  dir_d  = wd;
        PIO_MASK: mask_d = wd;
        PIO_EDGE: cap_d  = cap_q & ~wd;
        PIO_SET:  data_d = data_q | wd;
        PIO_CLR:  data_d = data_q & ~wd;
        default:  ;
      endcase
    end

    // New edges are OR-ed in after the software clear so a coincident
    // edge is never lost.
    cap_d = cap_d | edge_det;

    if (IRQ_TYPE == IRQ_LEVEL) begin
      irq_d = |(sync_in & mask_q);
    end else begin
      irq_d = |(cap_q & mask_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  // Combinational read mux; driven bits read back the output register,
  // undriven bits read the synchronised pin.
  always_comb begin
    rd_val = '0;
    if (chipselect) begin
      unique case (address)
        PIO_DATA: rd_val = (dir_q & data_q) | (~dir_q & sync_in);
        PIO_DIR:  rd_val = dir_q;
        PIO_MASK: rd_val = mask_q;
        PIO_EDGE: rd_val = cap_q;
        default:  rd_val = '0;
      endcase
    end
  end

  assign readdata = 32'(rd_val);
  assign out_port = data_q;
  assign out_en   = dir_q;
  assign irq      = irq_q;

endmodule
